// File: rtl/rf_scoreboard.sv
// rf_scoreboard
// Decode-stage register file with a per-register pending-write scoreboard.
// Register 0 is hardwired to zero. Every read port sees a write-through
// bypass of the write-back port, both for data and for readiness, so decode
// can detect RAW hazards directly from rd_ready.
//
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous active-high reset (clears array and counters)
//   rd_addr      NREAD packed read addresses, port k at [k*ADDR_W +: ADDR_W]
//   rd_data      NREAD packed read values,    port k at [k*DATA_W +: DATA_W]
//   rd_ready     per port: operand has no outstanding write after this cycle
//   iss_en       mark iss_addr as having one more in-flight write
//   iss_addr     destination being issued
//   iss_stall    issue refused this cycle (counter saturated)
//   wr_en        write-back strobe
//   wr_addr      write-back destination
//   wr_data      write-back value
//   wr_pc        PC of the writing instruction (trace output only)
//   any_pending  some register has a nonzero pending counter
module rf_scoreboard #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NREAD  = 2,
    parameter int CNT_W  = 2,
    parameter int TRACE  = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NREAD*ADDR_W-1:0]  rd_addr,
    output logic [NREAD*DATA_W-1:0]  rd_data,
    output logic [NREAD-1:0]         rd_ready,
    input  logic                     iss_en,
    input  logic [ADDR_W-1:0]        iss_addr,
    output logic                     iss_stall,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic [31:0]              wr_pc,
    output logic                     any_pending
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [DATA_W-1:0] mem [DEPTH];
    logic [CNT_W-1:0]  cnt [DEPTH];

    logic wr_live;
    logic iss_full;
    logic iss_acc;

    // Reset gates the request strobes so a held reset has no side effects,
    // even on the combinational bypass paths.
    assign wr_live = wr_en && !reset && (wr_addr != '0);

    // A write landing on the same register in the same cycle frees a slot,
    // so a saturated counter can still accept the issue.
    assign iss_full  = (cnt[iss_addr] == CNT_MAX) && !(wr_en && wr_addr == iss_addr);
    assign iss_stall = !reset && iss_en && (iss_addr != '0) && iss_full;
    assign iss_acc   = !reset && iss_en && (iss_addr != '0) && !iss_full;

    // Register array
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_live) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Pending counters; entry 0 never moves
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int r = 1; r < DEPTH; r++) begin
                logic inc;
                logic dec;
                inc = iss_acc && (iss_addr == ADDR_W'(r));
                dec = wr_en && (wr_addr == ADDR_W'(r)) && (cnt[r] != '0);
                if (inc && !dec) begin
                    cnt[r] <= cnt[r] + 1'b1;
                end else if (dec && !inc) begin
                    cnt[r] <= cnt[r] - 1'b1;
                end
            end
        end
    end

    // Read ports with data and readiness bypass
    for (genvar k = 0; k < NREAD; k++) begin : g_rd
        logic [ADDR_W-1:0] a;
        logic [CNT_W-1:0]  c;
        logic              hit;

        assign a   = rd_addr[k*ADDR_W +: ADDR_W];
        assign c   = cnt[a];
        assign hit = wr_live && (wr_addr == a);

        assign rd_data[k*DATA_W +: DATA_W] =
            (reset || a == '0) ? '0 :
            hit                ? wr_data :
                                 mem[a];

        // Ready when nothing is outstanding, or the last outstanding write
        // is landing right now.
        assign rd_ready[k] = reset || (a == '0) || (c == '0) ||
                             (c == CNT_W'(1) && hit);
    end

    always_comb begin
        any_pending = 1'b0;
        for (int i = 1; i < DEPTH; i++) begin
            if (cnt[i] != '0) begin
                any_pending = 1'b1;
            end
        end
        if (reset) begin
            any_pending = 1'b0;
        end
    end

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (TRACE != 0 && wr_live) begin
            $display("@%h: $%0d <= %h", wr_pc, wr_addr, wr_data);
        end
    end
`endif

endmodule

// File: tb/tb_rf_scoreboard.sv
module tb_rf_scoreboard;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int NREAD  = 4;
    localparam int CNT_W  = 2;

    logic                    clk = 1'b0;
    logic                    reset;
    logic [NREAD*ADDR_W-1:0] rd_addr;
    logic [NREAD*DATA_W-1:0] rd_data;
    logic [NREAD-1:0]        rd_ready;
    logic                    iss_en;
    logic [ADDR_W-1:0]       iss_addr;
    logic                    iss_stall;
    logic                    wr_en;
    logic [ADDR_W-1:0]       wr_addr;
    logic [DATA_W-1:0]       wr_data;
    logic [31:0]             wr_pc;
    logic                    any_pending;

    int checks = 0;
    int errors = 0;

    rf_scoreboard #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NREAD(NREAD), .CNT_W(CNT_W), .TRACE(1)
    ) dut (
        .clk(clk), .reset(reset),
        .rd_addr(rd_addr), .rd_data(rd_data), .rd_ready(rd_ready),
        .iss_en(iss_en), .iss_addr(iss_addr), .iss_stall(iss_stall),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_pc(wr_pc),
        .any_pending(any_pending)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_rd(input int k, input logic [ADDR_W-1:0] a);
        rd_addr[k*ADDR_W +: ADDR_W] = a;
    endtask

    function automatic logic [DATA_W-1:0] port_data(input int k);
        return rd_data[k*DATA_W +: DATA_W];
    endfunction

    task automatic test_reset();
        for (int k = 0; k < NREAD; k++) set_rd(k, 5'd5);
        #1;
        checks++;
        if (rd_data !== '0) begin
            errors++; $display("FAIL reset_rd_data got %h want 0", rd_data);
        end
        checks++;
        if (rd_ready !== 4'hF || iss_stall !== 1'b0 || any_pending !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags got rdy=%b stall=%b pend=%b want rdy=1111 stall=0 pend=0",
                     rd_ready, iss_stall, any_pending);
        end
    endtask

    task automatic test_reset_midrun();
        set_rd(0, 5'd3);
        wr_en = 1; wr_addr = 5'd3; wr_data = 32'h1234; wr_pc = 32'h100;
        tick();
        wr_en = 0;
        iss_en = 1; iss_addr = 5'd3;
        tick();
        iss_en = 0;
        #1;
        checks++;
        if (port_data(0) !== 32'h1234 || any_pending !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset got data=%h pend=%b want 1234 1", port_data(0), any_pending);
        end
        reset = 1;
        #1;
        checks++;
        if (port_data(0) !== 32'h0 || rd_ready[0] !== 1'b1 || any_pending !== 1'b0) begin
            errors++;
            $display("FAIL async_reset got data=%h rdy=%b pend=%b want 0 1 0",
                     port_data(0), rd_ready[0], any_pending);
        end
        // held reset must ignore write and issue
        wr_en = 1; wr_addr = 5'd3; wr_data = 32'hAAAA; iss_en = 1; iss_addr = 5'd3;
        #1;
        checks++;
        if (port_data(0) !== 32'h0 || iss_stall !== 1'b0) begin
            errors++;
            $display("FAIL reset_held_bypass got data=%h stall=%b want 0 0", port_data(0), iss_stall);
        end
        tick();
        wr_en = 0; iss_en = 0;
        #1;
        reset = 0;
        #1;
        checks++;
        if (port_data(0) !== 32'h0 || rd_ready[0] !== 1'b1 || any_pending !== 1'b0) begin
            errors++;
            $display("FAIL reset_held_ignored got data=%h rdy=%b pend=%b want 0 1 0",
                     port_data(0), rd_ready[0], any_pending);
        end
    endtask

    task automatic test_write_bypass();
        tick();
        set_rd(1, 5'd8);
        wr_en = 1; wr_addr = 5'd8; wr_data = 32'hDEADBEEF; wr_pc = 32'h200;
        #1;
        checks++;
        if (port_data(1) !== 32'hDEADBEEF) begin
            errors++; $display("FAIL bypass_same_cycle got %h want deadbeef", port_data(1));
        end
        tick();
        wr_en = 0;
        #1;
        checks++;
        if (port_data(1) !== 32'hDEADBEEF) begin
            errors++; $display("FAIL array_next_cycle got %h want deadbeef", port_data(1));
        end
        set_rd(2, 5'd0);
        wr_en = 1; wr_addr = 5'd0; wr_data = 32'hFFFFFFFF;
        #1;
        checks++;
        if (port_data(2) !== 32'h0) begin
            errors++; $display("FAIL r0_bypass got %h want 0", port_data(2));
        end
        tick();
        wr_en = 0;
        #1;
        checks++;
        if (port_data(2) !== 32'h0 || rd_ready[2] !== 1'b1) begin
            errors++; $display("FAIL r0_stored got %h rdy=%b want 0 1", port_data(2), rd_ready[2]);
        end
    endtask

    task automatic test_pending();
        set_rd(0, 5'd9);
        iss_en = 1; iss_addr = 5'd9;
        #1;
        checks++;
        if (iss_stall !== 1'b0 || rd_ready[0] !== 1'b1) begin
            errors++;
            $display("FAIL issue_cycle got stall=%b rdy=%b want 0 1", iss_stall, rd_ready[0]);
        end
        tick();
        iss_en = 0;
        #1;
        checks++;
        if (rd_ready[0] !== 1'b0 || any_pending !== 1'b1) begin
            errors++;
            $display("FAIL after_issue got rdy=%b pend=%b want 0 1", rd_ready[0], any_pending);
        end
        wr_en = 1; wr_addr = 5'd9; wr_data = 32'h99;
        #1;
        checks++;
        if (rd_ready[0] !== 1'b1 || port_data(0) !== 32'h99) begin
            errors++;
            $display("FAIL ready_bypass got rdy=%b data=%h want 1 99", rd_ready[0], port_data(0));
        end
        tick();
        wr_en = 0;
        #1;
        checks++;
        if (any_pending !== 1'b0 || rd_ready[0] !== 1'b1) begin
            errors++;
            $display("FAIL drained got pend=%b rdy=%b want 0 1", any_pending, rd_ready[0]);
        end
    endtask

    task automatic test_saturation();
        set_rd(0, 5'd4);
        iss_en = 1; iss_addr = 5'd4;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (iss_stall !== 1'b0) begin
                errors++; $display("FAIL issue_%0d_stall got %b want 0", i, iss_stall);
            end
            tick();
        end
        #1;
        checks++;
        if (iss_stall !== 1'b1) begin
            errors++; $display("FAIL fourth_issue_stall got %b want 1", iss_stall);
        end
        tick();
        checks++;
        if (iss_stall !== 1'b1) begin
            errors++; $display("FAIL stall_holds got %b want 1", iss_stall);
        end
        wr_en = 1; wr_addr = 5'd4; wr_data = 32'h44;
        #1;
        checks++;
        if (iss_stall !== 1'b0 || rd_ready[0] !== 1'b0) begin
            errors++;
            $display("FAIL issue_with_write got stall=%b rdy=%b want 0 0", iss_stall, rd_ready[0]);
        end
        tick();
        iss_en = 0;
        // count must still be 3: two more writes leave exactly one outstanding
        tick();
        tick();
        wr_en = 0;
        #1;
        checks++;
        if (rd_ready[0] !== 1'b0 || any_pending !== 1'b1) begin
            errors++;
            $display("FAIL count_kept_3 got rdy=%b pend=%b want 0 1", rd_ready[0], any_pending);
        end
        wr_en = 1;
        #1;
        checks++;
        if (rd_ready[0] !== 1'b1) begin
            errors++; $display("FAIL last_write_ready got %b want 1", rd_ready[0]);
        end
        tick();
        wr_en = 0;
        #1;
        checks++;
        if (any_pending !== 1'b0) begin
            errors++; $display("FAIL sat_drained got %b want 0", any_pending);
        end
    endtask

    task automatic test_write_no_pending();
        set_rd(3, 5'd6);
        wr_en = 1; wr_addr = 5'd6; wr_data = 32'h66;
        tick();
        wr_en = 0;
        #1;
        checks++;
        if (port_data(3) !== 32'h66 || rd_ready[3] !== 1'b1 || any_pending !== 1'b0) begin
            errors++;
            $display("FAIL no_underflow got data=%h rdy=%b pend=%b want 66 1 0",
                     port_data(3), rd_ready[3], any_pending);
        end
        // an issue right after must still be a single pending write
        iss_en = 1; iss_addr = 5'd6;
        tick();
        iss_en = 0;
        wr_en = 1; wr_addr = 5'd6; wr_data = 32'h67;
        #1;
        checks++;
        if (rd_ready[3] !== 1'b1) begin
            errors++; $display("FAIL no_underflow_single got %b want 1", rd_ready[3]);
        end
        tick();
        wr_en = 0;
    endtask

    task automatic test_multi_port();
        iss_en = 1; iss_addr = 5'd10;
        tick();
        iss_addr = 5'd11;
        tick();
        iss_en = 0;
        set_rd(0, 5'd10); set_rd(1, 5'd11); set_rd(2, 5'd12); set_rd(3, 5'd0);
        #1;
        checks++;
        if (rd_ready !== 4'b1100) begin
            errors++; $display("FAIL multi_initial got %b want 1100", rd_ready);
        end
        wr_en = 1; wr_addr = 5'd10; wr_data = 32'hA;
        #1;
        checks++;
        if (rd_ready !== 4'b1101) begin
            errors++; $display("FAIL multi_wr10 got %b want 1101", rd_ready);
        end
        tick();
        wr_addr = 5'd11; wr_data = 32'hB;
        #1;
        checks++;
        if (rd_ready !== 4'b1111 || port_data(1) !== 32'hB || port_data(0) !== 32'hA) begin
            errors++;
            $display("FAIL multi_wr11 got rdy=%b d0=%h d1=%h want 1111 a b",
                     rd_ready, port_data(0), port_data(1));
        end
        tick();
        wr_en = 0;
        #1;
        checks++;
        if (any_pending !== 1'b0 || rd_ready !== 4'b1111) begin
            errors++;
            $display("FAIL multi_drained got pend=%b rdy=%b want 0 1111", any_pending, rd_ready);
        end
    endtask

    task automatic test_trace();
        set_rd(0, 5'd31);
        wr_en = 1; wr_addr = 5'd31; wr_data = 32'h00003008; wr_pc = 32'h00003004;
        tick();
        wr_en = 0;
        #1;
        checks++;
        if (port_data(0) !== 32'h00003008) begin
            errors++; $display("FAIL trace_write got %h want 00003008", port_data(0));
        end
    endtask

    initial begin
        reset = 1; rd_addr = '0; iss_en = 0; iss_addr = '0;
        wr_en = 0; wr_addr = '0; wr_data = '0; wr_pc = '0;
        tick();
        tick();
        test_reset();
        reset = 0;
        tick();
        test_reset();
        test_reset_midrun();
        test_write_bypass();
        test_pending();
        test_saturation();
        test_write_no_pending();
        test_multi_port();
        test_trace();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
